// File: rtl/proc_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
//   Shared processor definitions used by the data stack and its RAM.
//   - NBDATA_DFLT : default data word width (accumulator/ALU width)
//   - stk_op_t    : stack operation formed as {push, pop}
//   - depth()     : stack capacity in words for a given address width
// ----------------------------------------------------------------------------
package proc_pkg;

   localparam int NBDATA_DFLT = 32;

   // Operation code as seen by the stack, built directly from {push, pop}.
   typedef enum logic [1:0] {
      STK_NOP  = 2'd0,
      STK_POP  = 2'd1,
      STK_PUSH = 2'd2,
      STK_REPL = 2'd3
   } stk_op_t;

   // Total capacity, TOS register included.
   function automatic int depth(input int nbstck);
      return 1 << nbstck;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// ----------------------------------------------------------------------------
// stack_ram
//   Register-file RAM holding the lower stack entries (everything below TOS).
//   Synchronous write, asynchronous read, contents not reset. Kept as a plain
//   array so it maps onto distributed RAM or can be swapped for a primitive.
//
//   Ports:
//     clk    in   clock, rising edge
//     we     in   write enable
//     waddr  in   write address  [NBSTCK-1:0]
//     wdata  in   write data     [NBDATA-1:0]
//     raddr  in   read address   [NBSTCK-1:0]
//     rdata  out  read data      [NBDATA-1:0], combinational from raddr
// ----------------------------------------------------------------------------
module stack_ram
   import proc_pkg::*;
#(
   parameter int NBDATA = NBDATA_DFLT,
   parameter int NBSTCK = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [NBSTCK-1:0] waddr,
   input  logic [NBDATA-1:0] wdata,
   input  logic [NBSTCK-1:0] raddr,
   output logic [NBDATA-1:0] rdata
);

   logic [NBDATA-1:0] mem [depth(NBSTCK)];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack_fx.sv
// ----------------------------------------------------------------------------
// data_stack_fx
//   Hardware LIFO serving the decoder's dsp_push/dsp_pop strobes. The top of
//   stack lives in a register so the ALU can consume it in the same cycle the
//   popping instruction executes; lower entries live in stack_ram.
//
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous active-high reset
//     push     in   push din onto the stack
//     pop      in   remove TOS (push & pop together = replace TOS)
//     din      in   word to push              [NBDATA-1:0]
//     clr_err  in   synchronous clear of ovf/udf
//     tos      out  registered top of stack   [NBDATA-1:0]
//     nos      out  next of stack, 0 when fewer than two entries
//     count    out  number of valid entries   [NBSTCK:0], 0..DEPTH
//     empty    out  count == 0
//     full     out  count == DEPTH
//     ovf      out  sticky: push refused because the stack was full
//     udf      out  sticky: pop refused because the stack was empty
// ----------------------------------------------------------------------------
module data_stack_fx
   import proc_pkg::*;
#(
   parameter int NBDATA = NBDATA_DFLT,
   parameter int NBSTCK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [NBDATA-1:0] din,
   input  logic              clr_err,
   output logic [NBDATA-1:0] tos,
   output logic [NBDATA-1:0] nos,
   output logic [NBSTCK:0]   count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              udf
);

   localparam int              DEPTH     = depth(NBSTCK);
   localparam logic [NBSTCK:0] CNT_ZERO  = '0;
   localparam logic [NBSTCK:0] CNT_ONE   = (NBSTCK+1)'(1);
   localparam logic [NBSTCK:0] CNT_TWO   = (NBSTCK+1)'(2);
   localparam logic [NBSTCK:0] CNT_DEPTH = (NBSTCK+1)'(DEPTH);
   localparam logic [NBSTCK-1:0] IDX_ONE = NBSTCK'(1);
   localparam logic [NBSTCK-1:0] IDX_TWO = NBSTCK'(2);

   logic [NBDATA-1:0] tos_reg, tos_next;
   logic [NBSTCK:0]   count_reg, count_next;
   logic              ovf_reg, ovf_next;
   logic              udf_reg, udf_next;

   logic              ram_we;
   logic [NBSTCK-1:0] ram_waddr;
   logic [NBSTCK-1:0] ram_raddr;
   logic [NBDATA-1:0] ram_rdata;
   logic [NBSTCK-1:0] count_lo;
   logic              empty_int;
   logic              full_int;
   stk_op_t           op;

   // Status is decoded from the registered count only, never from the strobes.
   assign empty_int = (count_reg == CNT_ZERO);
   assign full_int  = (count_reg == CNT_DEPTH);

   // The low NBSTCK bits of count are enough for RAM addressing: the write
   // address (count-1) is only used when not full, and for the read address
   // (count-2) the full case wraps the low bits to exactly DEPTH-2.
   assign count_lo  = count_reg[NBSTCK-1:0];
   assign ram_waddr = count_lo - IDX_ONE;
   assign ram_raddr = count_lo - IDX_TWO;

   assign op = stk_op_t'({push, pop});

   stack_ram #(
      .NBDATA (NBDATA),
      .NBSTCK (NBSTCK)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (tos_reg),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   always_comb begin
      tos_next   = tos_reg;
      count_next = count_reg;
      ram_we     = 1'b0;
      // A new error raised this cycle overrides a simultaneous clear.
      ovf_next   = ovf_reg & ~clr_err;
      udf_next   = udf_reg & ~clr_err;

      case (op)
         STK_PUSH: begin
            if (full_int) begin
               ovf_next = 1'b1;
            end else begin
               // The old TOS sinks into RAM; nothing to spill when empty.
               ram_we     = ~empty_int;
               tos_next   = din;
               count_next = count_reg + CNT_ONE;
            end
         end
         STK_POP: begin
            if (empty_int) begin
               udf_next = 1'b1;
            end else if (count_reg >= CNT_TWO) begin
               tos_next   = ram_rdata;
               count_next = count_reg - CNT_ONE;
            end else begin
               tos_next   = '0;
               count_next = CNT_ZERO;
            end
         end
         STK_REPL: begin
            // Replace never touches RAM and is never flagged; on an empty
            // stack it degenerates to a plain push.
            tos_next = din;
            if (empty_int) begin
               count_next = CNT_ONE;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tos_reg   <= '0;
         count_reg <= CNT_ZERO;
         ovf_reg   <= 1'b0;
         udf_reg   <= 1'b0;
      end else begin
         tos_reg   <= tos_next;
         count_reg <= count_next;
         ovf_reg   <= ovf_next;
         udf_reg   <= udf_next;
      end
   end

   assign tos   = tos_reg;
   assign nos   = (count_reg >= CNT_TWO) ? ram_rdata : '0;
   assign count = count_reg;
   assign empty = empty_int;
   assign full  = full_int;
   assign ovf   = ovf_reg;
   assign udf   = udf_reg;

endmodule

// File: tb/tb_data_stack_fx.sv
// ----------------------------------------------------------------------------
// tb_data_stack_fx
//   Self-checking bench for data_stack_fx with NBSTCK=2 (DEPTH=4). A queue
//   model of the LIFO is compared against the DUT on every falling edge, and
//   directed sequences pin the model with hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_data_stack_fx;

   localparam int NBDATA = 32;
   localparam int NBSTCK = 2;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic [NBDATA-1:0] din = '0;
   logic              clr_err = 1'b0;
   logic [NBDATA-1:0] tos;
   logic [NBDATA-1:0] nos;
   logic [NBSTCK:0]   count;
   logic              empty;
   logic              full;
   logic              ovf;
   logic              udf;

   int errors = 0;
   int checks = 0;

   data_stack_fx #(
      .NBDATA (NBDATA),
      .NBSTCK (NBSTCK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .din     (din),
      .clr_err (clr_err),
      .tos     (tos),
      .nos     (nos),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .ovf     (ovf),
      .udf     (udf)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: a plain queue, top at the back -------
   logic [NBDATA-1:0] stk[$];
   logic              m_ovf = 1'b0;
   logic              m_udf = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stk.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         if (clr_err) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         if (push && !pop) begin
            if (stk.size() < DEPTH) stk.push_back(din);
            else m_ovf = 1'b1;
         end else if (!push && pop) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else m_udf = 1'b1;
         end else if (push && pop) begin
            if (stk.size() == 0) stk.push_back(din);
            else stk[stk.size()-1] = din;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown({push, pop}))
            else $error("push/pop unknown outside reset");
      end
   end

   task automatic check(input string name, input logic [NBDATA-1:0] act,
                        input logic [NBDATA-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare against the model -------------------
   always @(negedge clk) begin
      if (!rst) begin
         int n;
         n = stk.size();
         check("m.tos",   tos,   (n > 0) ? stk[n-1] : '0);
         check("m.nos",   nos,   (n > 1) ? stk[n-2] : '0);
         check("m.count", 32'(count), 32'(n));
         check("m.empty", 32'(empty), 32'(n == 0));
         check("m.full",  32'(full),  32'(n == DEPTH));
         check("m.ovf",   32'(ovf),   32'(m_ovf));
         check("m.udf",   32'(udf),   32'(m_udf));
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   // Called at a falling edge: apply inputs, then wait one full cycle.
   task automatic cyc(input logic p, input logic q, input logic [NBDATA-1:0] d,
                      input logic c);
      push    = p;
      pop     = q;
      din     = d;
      clr_err = c;
      @(negedge clk);
      $display("op push=%0b pop=%0b din=0x%0h clr=%0b -> tos=0x%0h nos=0x%0h count=%0d ovf=%0b udf=%0b",
               p, q, d, c, tos, nos, count, ovf, udf);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset();
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- directed sequences + random run ------------------------
   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst.tos",   tos, 32'h0);
      check("rst.count", 32'(count), 32'd0);
      check("rst.empty", 32'(empty), 32'd1);
      check("rst.full",  32'(full),  32'd0);
      check("rst.ovf",   32'(ovf),   32'd0);
      check("rst.udf",   32'(udf),   32'd0);

      // 1: three pushes
      cyc(1, 0, 32'h11, 0);
      cyc(1, 0, 32'h22, 0);
      cyc(1, 0, 32'h33, 0);
      check("t1.tos",   tos, 32'h33);
      check("t1.nos",   nos, 32'h22);
      check("t1.count", 32'(count), 32'd3);
      check("t1.empty", 32'(empty), 32'd0);
      check("t1.full",  32'(full),  32'd0);
      idle();

      // 2: fill, overflow, drain
      do_reset();
      cyc(1, 0, 32'hA1, 0);
      cyc(1, 0, 32'hA2, 0);
      cyc(1, 0, 32'hA3, 0);
      cyc(1, 0, 32'hA4, 0);
      cyc(1, 0, 32'hA5, 0);
      check("t2.count", 32'(count), 32'd4);
      check("t2.full",  32'(full),  32'd1);
      check("t2.ovf",   32'(ovf),   32'd1);
      check("t2.tos",   tos, 32'hA4);
      check("t2.nos",   nos, 32'hA3);
      cyc(0, 1, '0, 0); check("t2.pop1", tos, 32'hA3);
      cyc(0, 1, '0, 0); check("t2.pop2", tos, 32'hA2);
      cyc(0, 1, '0, 0); check("t2.pop3", tos, 32'hA1);
      cyc(0, 1, '0, 0); check("t2.pop4", tos, 32'h0);
      check("t2.empty", 32'(empty), 32'd1);

      // 3: underflow and clearing (ovf still set from step 2)
      cyc(0, 1, '0, 0);
      check("t3.udf",   32'(udf),   32'd1);
      check("t3.count", 32'(count), 32'd0);
      check("t3.tos",   tos, 32'h0);
      cyc(0, 0, '0, 1);
      check("t3.clr.udf", 32'(udf), 32'd0);
      check("t3.clr.ovf", 32'(ovf), 32'd0);
      cyc(0, 1, '0, 1);
      check("t3.win.udf", 32'(udf), 32'd1);
      idle();

      // 4: replace, including when full
      do_reset();
      cyc(1, 0, 32'h4, 0);
      cyc(1, 0, 32'h5, 0);
      cyc(1, 1, 32'h9, 0);
      check("t4.tos",   tos, 32'h9);
      check("t4.nos",   nos, 32'h4);
      check("t4.count", 32'(count), 32'd2);
      cyc(1, 0, 32'hB, 0);
      cyc(1, 0, 32'hC, 0);
      cyc(1, 1, 32'hD, 0);
      check("t4.full.ovf",   32'(ovf), 32'd0);
      check("t4.full.count", 32'(count), 32'd4);
      check("t4.full.tos",   tos, 32'hD);
      check("t4.full.nos",   nos, 32'hB);
      idle();

      // 5: asynchronous reset in the middle of a push
      cyc(0, 1, '0, 0);
      push = 1'b1; din = 32'h77;
      #2 rst = 1'b1;
      #1;
      check("t5.async.tos",   tos, 32'h0);
      check("t5.async.count", 32'(count), 32'd0);
      check("t5.async.empty", 32'(empty), 32'd1);
      push = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 0, 32'h1, 0);
      check("t5.tos",   tos, 32'h1);
      check("t5.count", 32'(count), 32'd1);
      idle();

      // 6: random push/pop/replace/clear, checked every cycle by the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         logic p, q, c;
         p = ($urandom_range(0, 99) < 50);
         q = ($urandom_range(0, 99) < 45);
         c = ($urandom_range(0, 99) < 5);
         cyc(p, q, $urandom, c);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
